register_file_mp: RTL

- Parametrised multi-port integer register file: next generation of the single-write, dual-read register_file.
- Adds a configurable read-port count, two prioritised write ports, optional write-to-read bypass and a hardwired zero register.
- Adds a per-register busy scoreboard for hazard detection and a sequenced clear engine.
- Sits between decode/issue (reads, reservations) and writeback (two retire lanes) in the CPU pipeline.

---
 rtl/register_file_mp.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port integer register file.
//   - NRD combinational read ports (packed raddr/rdata, per-port rbusy)
//   - two write lanes, lane 1 wins on an address collision
//   - optional same-cycle write-to-read forwarding and hardwired zero register
//   - per-register busy scoreboard (reserve sets, write clears, reserve wins)
//   - clear engine that zeroes one register and its busy bit per cycle
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   raddr / rdata / rbusy       read addresses, read data, busy flags
//   we0/waddr0/wdata0           write lane 0
//   we1/waddr1/wdata1           write lane 1 (higher priority)
//   rsv_en/rsv_addr             scoreboard reservation
//   clr_req                     start a clear sweep (sampled in IDLE)
//   clr_busy/clr_done/wr_drop   sweep status (registered)
module register_file_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = $clog2(NREG),
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                wr_drop
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     busy_q, busy_d;
  logic                clr_busy_q, clr_busy_d;
  logic                clr_done_q, clr_done_d;
  logic                wr_drop_q, wr_drop_d;

  // Lane qualifiers: address 0 is inert when the zero register is hardwired.
  logic                w0_ok, w1_ok, rsv_ok;
  assign w0_ok  = we0    && !(ZR && (waddr0   == '0));
  assign w1_ok  = we1    && !(ZR && (waddr1   == '0));
  assign rsv_ok = rsv_en && !(ZR && (rsv_addr == '0));

  // Next-state: writes and reservations in IDLE, one-register-per-cycle sweep in CLEAR.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    regs_d     = regs_q;
    busy_d     = busy_q;
    clr_done_d = 1'b0;
    wr_drop_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w0_ok) begin
          regs_d[waddr0] = wdata0;
          busy_d[waddr0] = 1'b0;
        end
        if (w1_ok) begin
          regs_d[waddr1] = wdata1;
          busy_d[waddr1] = 1'b0;
        end
        // Reservation last: it belongs to a younger instruction than the retiring write.
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;
        if (clr_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        regs_d[ptr_q] = '0;
        busy_d[ptr_q] = 1'b0;
        wr_drop_d     = we0 || we1 || rsv_en;
        if (ptr_q == AW'(NREG - 1)) begin
          state_d    = S_IDLE;
          ptr_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
    clr_busy_d = (state_d == S_CLEAR);
  end

  // State, storage and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      busy_q     <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;

  // Read ports: zero register, then forwarding (lane 1 over lane 0), else stored value.
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rd;
  logic            rb;
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    rb    = 1'b0;
    for (int i = 0; i < int'(NRD); i++) begin
      ra = raddr[i*AW +: AW];
      rd = regs_q[ra];
      rb = busy_q[ra];
      if (ZR && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end else if (BP && (state_q == S_IDLE)) begin
        if (we0 && (waddr0 == ra)) rd = wdata0;
        if (we1 && (waddr1 == ra)) rd = wdata1;
      end
      rdata[i*XLEN +: XLEN] = rd;
      rbusy[i]              = rb;
    end
  end

endmodule
